fireball_projectile: RTL and testbench

FIREBALL_PROJECTILE -- requirements
Module: fireball_projectile

---
 rtl/fireball_projectile.sv | 121 ++++++++++++
 tb/tb_fireball_projectile.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fireball_projectile.sv
// Fireball projectile: launches beside a shooter, steps horizontally once per frame tick,
// ends at a screen edge or on a hit, then blocks relaunch for a cooldown counted in frame ticks.
module fireball_projectile #(
   parameter int SPEED           = 4,
   parameter int SPRITE_W        = 16,
   parameter int SPRITE_H        = 11,
   parameter int Y_OFFSET        = 20,
   parameter int SCREEN_W        = 640,
   parameter int COOLDOWN_FRAMES = 30
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic       fire_req,
   input  logic       player_or_npc,
   input  logic [9:0] shooter_x,
   input  logic [9:0] shooter_y,
   input  logic [9:0] shooter_size_x,
   input  logic       hit,
   output logic [9:0] proj_x_curr,
   output logic [9:0] proj_y_curr,
   output logic       fire_active,
   output logic       hit_ack,
   output logic       ready
);
   localparam int CW = ($clog2(COOLDOWN_FRAMES + 1) > 5) ? $clog2(COOLDOWN_FRAMES + 1) : 5;

   typedef enum logic [1:0] {IDLE, FLY, COOLDOWN} state_t;

   state_t        state, state_nxt;
   logic [9:0]    x_q, x_nxt, y_q, y_nxt;
   logic          dir_q, dir_nxt;
   logic [CW-1:0] cnt_q, cnt_nxt;
   logic          hit_ack_q, hit_ack_nxt;
   logic          frame_prev;
   logic          frame_tick;
   logic [9:0]    launch_x;
   logic [10:0]   launch_sum;
   logic [10:0]   right_sum;
   logic          launch_ok;
   logic          at_edge;

   assign frame_tick = frame_clk & ~frame_prev;

   // Edge checks use 11-bit sums so a position near 1023 cannot wrap past the screen test.
   assign launch_x   = player_or_npc ? (shooter_x + shooter_size_x) : (shooter_x - 10'(SPRITE_W));
   assign launch_sum = {1'b0, launch_x} + 11'(SPRITE_W);
   assign launch_ok  = player_or_npc ? (launch_sum <= 11'(SCREEN_W)) : (shooter_x >= 10'(SPRITE_W));
   assign right_sum  = {1'b0, x_q} + 11'(SPEED + SPRITE_W);
   assign at_edge    = dir_q ? (right_sum > 11'(SCREEN_W)) : (x_q < 10'(SPEED));

   always_comb begin
      state_nxt   = state;
      x_nxt       = x_q;
      y_nxt       = y_q;
      dir_nxt     = dir_q;
      cnt_nxt     = cnt_q;
      hit_ack_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (fire_req && launch_ok) begin
               state_nxt = FLY;
               x_nxt     = launch_x;
               y_nxt     = shooter_y + 10'(Y_OFFSET);
               dir_nxt   = player_or_npc;
            end
         end
         FLY: begin
            // A hit wins over an edge or a move in the same cycle.
            if (hit) begin
               hit_ack_nxt = 1'b1;
               state_nxt   = COOLDOWN;
               cnt_nxt     = CW'(COOLDOWN_FRAMES);
            end else if (frame_tick) begin
               if (at_edge) begin
                  state_nxt = COOLDOWN;
                  cnt_nxt   = CW'(COOLDOWN_FRAMES);
               end else begin
                  x_nxt = dir_q ? (x_q + 10'(SPEED)) : (x_q - 10'(SPEED));
               end
            end
         end
         COOLDOWN: begin
            if (cnt_q == '0) begin
               state_nxt = IDLE;
            end else if (frame_tick) begin
               cnt_nxt = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         dir_q      <= 1'b0;
         cnt_q      <= '0;
         hit_ack_q  <= 1'b0;
         frame_prev <= 1'b0;
      end else begin
         state      <= state_nxt;
         x_q        <= x_nxt;
         y_q        <= y_nxt;
         dir_q      <= dir_nxt;
         cnt_q      <= cnt_nxt;
         hit_ack_q  <= hit_ack_nxt;
         frame_prev <= frame_clk;
      end
   end

   assign proj_x_curr = x_q;
   assign proj_y_curr = y_q;
   assign fire_active = (state == FLY);
   assign ready       = (state == IDLE);
   assign hit_ack     = hit_ack_q;

endmodule

// File: tb/tb_fireball_projectile.sv
// Bench for fireball_projectile: randomized traffic against a behavioural model,
// plus hand-worked launch, edge, hit, suppression and reset scenarios.
module tb_fireball_projectile;
   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic       fire_req;
   logic       player_or_npc;
   logic [9:0] shooter_x;
   logic [9:0] shooter_y;
   logic [9:0] shooter_size_x;
   logic       hit;
   logic [9:0] proj_x_curr;
   logic [9:0] proj_y_curr;
   logic       fire_active;
   logic       hit_ack;
   logic       ready;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   // Model: 0 = waiting for launch, 1 = flying, 2 = cooling down.
   int m_mode, m_x, m_y, m_cnt;
   bit m_dir, m_ack, m_fprev;

   fireball_projectile dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire_req(fire_req),
      .player_or_npc(player_or_npc), .shooter_x(shooter_x), .shooter_y(shooter_y),
      .shooter_size_x(shooter_size_x), .hit(hit), .proj_x_curr(proj_x_curr),
      .proj_y_curr(proj_y_curr), .fire_active(fire_active), .hit_ack(hit_ack), .ready(ready)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mode = 0; m_x = 0; m_y = 0; m_cnt = 0;
      m_dir = 0; m_ack = 0; m_fprev = 0;
   endfunction

   // One clock of the block's rules, using the inputs present at that edge.
   function automatic void model_step();
      bit tick;
      int lx;
      bit ok;
      if (Reset) begin
         model_reset();
         return;
      end
      tick    = frame_clk && !m_fprev;
      m_fprev = frame_clk;
      m_ack   = 0;
      if (m_mode == 0) begin
         if (fire_req) begin
            if (player_or_npc) begin
               lx = (int'(shooter_x) + int'(shooter_size_x)) % 1024;
               ok = (lx + 16) <= 640;
            end else begin
               lx = int'(shooter_x) - 16;
               ok = int'(shooter_x) >= 16;
            end
            if (ok) begin
               m_mode = 1;
               m_x    = lx;
               m_y    = (int'(shooter_y) + 20) % 1024;
               m_dir  = player_or_npc;
            end
         end
      end else if (m_mode == 1) begin
         if (hit) begin
            m_ack  = 1;
            m_mode = 2;
            m_cnt  = 30;
         end else if (tick) begin
            if (m_dir) begin
               if (m_x + 4 + 16 > 640) begin m_mode = 2; m_cnt = 30; end
               else m_x = m_x + 4;
            end else begin
               if (m_x < 4) begin m_mode = 2; m_cnt = 30; end
               else m_x = m_x - 4;
            end
         end
      end else begin
         if (tick) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_mode = 0;
         end
      end
   endfunction

   always @(negedge Clk) begin
      if (chk_en) begin
         check("model_x", int'(proj_x_curr), m_x);
         check("model_y", int'(proj_y_curr), m_y);
         check("model_fire_active", int'(fire_active), int'(m_mode == 1));
         check("model_hit_ack", int'(hit_ack), int'(m_ack));
         check("model_ready", int'(ready), int'(m_mode == 0));
      end
   end

   task automatic step();
      @(posedge Clk);
      model_step();
      #1;
   endtask

   task automatic tick_frame();
      frame_clk = 1'b1;
      step();
      frame_clk = 1'b0;
      step();
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      #1;
      model_reset();
      check("rst_x", int'(proj_x_curr), 0);
      check("rst_y", int'(proj_y_curr), 0);
      check("rst_fire_active", int'(fire_active), 0);
      check("rst_hit_ack", int'(hit_ack), 0);
      check("rst_ready", int'(ready), 1);
      step();
      Reset = 1'b0;
   endtask

   task automatic launch(input bit dir, input int sx, input int sz, input int sy);
      player_or_npc  = dir;
      shooter_x      = 10'(sx);
      shooter_size_x = 10'(sz);
      shooter_y      = 10'(sy);
      fire_req       = 1'b1;
      step();
      fire_req       = 1'b0;
   endtask

   initial begin
      int launches;
      bit prev_fa;
      Reset = 1'b1; frame_clk = 0; fire_req = 0; player_or_npc = 0;
      shooter_x = 0; shooter_y = 0; shooter_size_x = 0; hit = 0;
      #1;
      model_reset();
      chk_en = 1;
      step();
      Reset = 1'b0;
      check("init_ready", int'(ready), 1);
      check("init_x", int'(proj_x_curr), 0);

      // Player launch and three moves.
      check("pre_launch_fa", int'(fire_active), 0);
      launch(1'b1, 100, 40, 300);
      check("p_launch_x", int'(proj_x_curr), 140);
      check("p_launch_y", int'(proj_y_curr), 320);
      check("p_launch_fa", int'(fire_active), 1);
      check("p_launch_ready", int'(ready), 0);
      repeat (3) tick_frame();
      check("p_3ticks_x", int'(proj_x_curr), 152);
      check("p_3ticks_y", int'(proj_y_curr), 320);

      // Right edge: 620 -> 624 is legal, from 624 the next step would exceed 640.
      do_reset();
      launch(1'b1, 600, 20, 50);
      check("r_launch_x", int'(proj_x_curr), 620);
      tick_frame();
      check("r_move_x", int'(proj_x_curr), 624);
      tick_frame();
      check("r_term_x", int'(proj_x_curr), 624);
      check("r_term_fa", int'(fire_active), 0);
      check("r_term_ready", int'(ready), 0);
      repeat (29) tick_frame();
      check("r_cool29_ready", int'(ready), 0);
      tick_frame();
      check("r_cool30_ready", int'(ready), 1);
      launch(1'b1, 600, 25, 50);
      check("r_suppress_ready", int'(ready), 1);
      check("r_suppress_x", int'(proj_x_curr), 624);
      launch(1'b1, 600, 24, 60);
      check("r_exact_fit_x", int'(proj_x_curr), 624);
      check("r_exact_fit_fa", int'(fire_active), 1);

      // NPC flight to the left edge.
      do_reset();
      launch(1'b0, 30, 40, 100);
      check("n_launch_x", int'(proj_x_curr), 14);
      tick_frame(); check("n_x10", int'(proj_x_curr), 10);
      tick_frame(); check("n_x6", int'(proj_x_curr), 6);
      tick_frame(); check("n_x2", int'(proj_x_curr), 2);
      tick_frame();
      check("n_term_x", int'(proj_x_curr), 2);
      check("n_term_fa", int'(fire_active), 0);

      // Hit on the same clock as an edge-terminating tick.
      do_reset();
      launch(1'b0, 18, 40, 100);
      check("h_launch_x", int'(proj_x_curr), 2);
      frame_clk = 1'b1; hit = 1'b1;
      step();
      hit = 1'b0;
      check("h_ack", int'(hit_ack), 1);
      check("h_x", int'(proj_x_curr), 2);
      check("h_fa", int'(fire_active), 0);
      step();
      check("h_ack_pulse", int'(hit_ack), 0);
      hit = 1'b1;
      step();
      hit = 1'b0;
      check("h_cool_ignored", int'(hit_ack), 0);
      frame_clk = 1'b0;

      // NPC too close to the left edge, and a hit while idle.
      do_reset();
      launch(1'b0, 10, 40, 100);
      check("s_npc_ready", int'(ready), 1);
      check("s_npc_fa", int'(fire_active), 0);
      hit = 1'b1;
      step();
      hit = 1'b0;
      check("s_idle_hit_ack", int'(hit_ack), 0);

      // fire_req held: one launch per idle visit.
      do_reset();
      player_or_npc = 1; shooter_x = 100; shooter_size_x = 40; shooter_y = 200;
      fire_req = 1'b1;
      launches = 0;
      prev_fa  = 0;
      for (int c = 0; c < 64; c++) begin
         hit       = (c == 3);
         frame_clk = c[0];
         step();
         if (fire_active && !prev_fa) launches++;
         prev_fa = fire_active;
      end
      hit = 1'b0;
      check("hold_launches", launches, 1);
      check("hold_back_idle", int'(ready), 1);
      step();
      check("hold_relaunch", int'(fire_active), 1);
      fire_req = 1'b0;
      frame_clk = 1'b0;

      // Reset mid-flight, then an immediate launch.
      do_reset();
      launch(1'b1, 260, 40, 80);
      check("m_launch_x", int'(proj_x_curr), 300);
      #2;
      do_reset();
      launch(1'b1, 260, 40, 80);
      check("m_relaunch_fa", int'(fire_active), 1);
      check("m_relaunch_x", int'(proj_x_curr), 300);

      // Randomized traffic; the negedge process compares against the model.
      for (int i = 0; i < 15000; i++) begin
         if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
         fire_req      = ($urandom_range(0, 5) == 0);
         player_or_npc = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       shooter_x = 10'($urandom_range(0, 31));
            1:       shooter_x = 10'($urandom_range(560, 639));
            default: shooter_x = 10'($urandom_range(0, 1023));
         endcase
         shooter_size_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                      : 10'($urandom_range(8, 64));
         shooter_y = 10'($urandom_range(0, 1023));
         hit       = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 4999) == 0) do_reset();
         step();
      end

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
